// File: rtl/tappy_tx.sv
// tappy two-wire serial transmitter: accepts a parallel word on valid/ready and
// shifts it out MSB first as a slow registered clk/dat pair derived from sysclk.
module tappy_tx #(
   parameter int WIDTH       = 8,
   parameter int HALF_PERIOD = 4,
   parameter int GAP_CYCLES  = 16
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] word,
   input  logic             valid,
   output logic             ready,
   output logic             clk,
   output logic             dat,
   output logic             done
);

   localparam int HMAX0 = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
   localparam int HMAX  = (HMAX0 > 2) ? HMAX0 : 2;
   localparam int HCW   = $clog2(HMAX) + 1;
   localparam int BCW   = $clog2(WIDTH) + 1;

   localparam logic [HCW-1:0] HP_LOAD  = HCW'(HALF_PERIOD - 1);
   localparam logic [HCW-1:0] GAP_LOAD = HCW'(GAP_CYCLES - 1);
   localparam logic [HCW-1:0] H_ONE    = HCW'(1);
   localparam logic [BCW-1:0] BIT_LOAD = BCW'(WIDTH - 1);
   localparam logic [BCW-1:0] B_ONE    = BCW'(1);

   if (HALF_PERIOD < 2) begin : g_bad_half_period
      $error("tappy_tx: HALF_PERIOD must be at least 2");
   end

   typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

   state_t           state_q, state_d;
   logic             clk_q, clk_d;
   logic             dat_q, dat_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] shifted;
   logic [HCW-1:0]   hcnt_q, hcnt_d;
   logic [BCW-1:0]   bcnt_q, bcnt_d;

   assign shifted = shreg_q << 1;

   // done takes the place of ready for one cycle so the two never overlap,
   // which also gives GAP_CYCLES=0 a single idle cycle before the next accept
   assign ready = (state_q == IDLE) && !done_q;
   assign clk   = clk_q;
   assign dat   = dat_q;
   assign done  = done_q;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         clk_q   <= 1'b0;
         dat_q   <= 1'b0;
         done_q  <= 1'b0;
         shreg_q <= '0;
         hcnt_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         clk_q   <= clk_d;
         dat_q   <= dat_d;
         done_q  <= done_d;
         shreg_q <= shreg_d;
         hcnt_q  <= hcnt_d;
         bcnt_q  <= bcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clk_d   = clk_q;
      dat_d   = dat_q;
      done_d  = 1'b0;
      shreg_d = shreg_q;
      hcnt_d  = hcnt_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         IDLE: begin
            clk_d = 1'b0;
            dat_d = 1'b0;
            if (valid && ready) begin
               shreg_d = word;
               bcnt_d  = BIT_LOAD;
               hcnt_d  = HP_LOAD;
               dat_d   = word[WIDTH-1];
               state_d = LOW;
            end
         end
         LOW: begin
            if (hcnt_q == '0) begin
               clk_d   = 1'b1;
               hcnt_d  = HP_LOAD;
               state_d = HIGH;
            end else begin
               hcnt_d = hcnt_q - H_ONE;
            end
         end
         HIGH: begin
            if (hcnt_q == '0) begin
               clk_d = 1'b0;
               if (bcnt_q != '0) begin
                  // next bit changes on the same edge that drops clk
                  shreg_d = shifted;
                  dat_d   = shifted[WIDTH-1];
                  bcnt_d  = bcnt_q - B_ONE;
                  hcnt_d  = HP_LOAD;
                  state_d = LOW;
               end else begin
                  dat_d   = 1'b0;
                  done_d  = 1'b1;
                  shreg_d = '0;
                  bcnt_d  = '0;
                  if (GAP_CYCLES == 0) begin
                     hcnt_d  = '0;
                     state_d = IDLE;
                  end else begin
                     hcnt_d  = GAP_LOAD;
                     state_d = GAP;
                  end
               end
            end else begin
               hcnt_d = hcnt_q - H_ONE;
            end
         end
         GAP: begin
            clk_d = 1'b0;
            dat_d = 1'b0;
            if (hcnt_q == '0) begin
               state_d = IDLE;
            end else begin
               hcnt_d = hcnt_q - H_ONE;
            end
         end
         default: begin
            clk_d   = 1'b0;
            dat_d   = 1'b0;
            hcnt_d  = '0;
            bcnt_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tappy_tx.sv
// Directed bench for tappy_tx: default instance plus a WIDTH=4/HALF_PERIOD=2/GAP=0 instance.
module tb_tappy_tx;

   logic       sysclk = 1'b0;
   logic       rst_n;
   logic [7:0] word;
   logic       valid;
   logic       ready, clk, dat, done;
   logic [3:0] word2;
   logic       valid2;
   logic       ready2, clk2, dat2, done2;

   int n_vec = 0;
   int n_err = 0;

   logic clk_tr  [0:255];
   logic dat_tr  [0:255];
   logic done_tr [0:255];
   logic rdy_tr  [0:255];
   logic clk2_tr [0:255];
   logic dat2_tr [0:255];
   logic done2_tr[0:255];
   logic rdy2_tr [0:255];

   logic       rx_prev = 1'b0;
   logic [7:0] rx_sh   = 8'h00;
   logic [7:0] rx_last = 8'h00;
   int         rx_bits = 0;
   int         rx_words = 0;

   always #5 sysclk = ~sysclk;

   tappy_tx dut (
      .sysclk(sysclk), .rst_n(rst_n), .word(word), .valid(valid),
      .ready(ready), .clk(clk), .dat(dat), .done(done)
   );

   tappy_tx #(.WIDTH(4), .HALF_PERIOD(2), .GAP_CYCLES(0)) dut2 (
      .sysclk(sysclk), .rst_n(rst_n), .word(word2), .valid(valid2),
      .ready(ready2), .clk(clk2), .dat(dat2), .done(done2)
   );

   // reference receiver: samples dat on each serial clk rising edge
   always @(negedge sysclk) begin
      if (clk && !rx_prev) begin
         rx_sh   = {rx_sh[6:0], dat};
         rx_bits = rx_bits + 1;
         if (rx_bits == 8) begin
            rx_words = rx_words + 1;
            rx_last  = rx_sh;
            rx_bits  = 0;
         end
      end
      rx_prev = clk;
   end

   task automatic accept(input logic [7:0] w, input bit hold);
      @(negedge sysclk);
      word  = w;
      valid = 1'b1;
      @(posedge sysclk);
      #1;
      if (!hold) valid = 1'b0;
   endtask

   task automatic accept2(input logic [3:0] w);
      @(negedge sysclk);
      word2  = w;
      valid2 = 1'b1;
      @(posedge sysclk);
      #1;
      valid2 = 1'b0;
   endtask

   // sample k holds the outputs registered at edge T+k
   task automatic capture(input int n, input int p1, input int p2);
      for (int k = 0; k < n; k++) begin
         @(negedge sysclk);
         clk_tr[k]   = clk;
         dat_tr[k]   = dat;
         done_tr[k]  = done;
         rdy_tr[k]   = ready;
         clk2_tr[k]  = clk2;
         dat2_tr[k]  = dat2;
         done2_tr[k] = done2;
         rdy2_tr[k]  = ready2;
         if (k == p1 || k == p2) begin
            valid = 1'b1;
            word  = 8'h00;
         end else if (p1 >= 0) begin
            valid = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      word   = 8'hFF;
      valid  = 1'b1;
      word2  = 4'hF;
      valid2 = 1'b1;
      repeat (3) @(negedge sysclk);
      n_vec++;
      if ({clk, dat, done, ready} !== 4'b0001) begin
         n_err++;
         $display("FAIL reset_outputs: clk/dat/done/ready=%b expected 0001", {clk, dat, done, ready});
      end
      n_vec++;
      if ({clk2, dat2, done2, ready2} !== 4'b0001) begin
         n_err++;
         $display("FAIL reset_outputs2: clk/dat/done/ready=%b expected 0001", {clk2, dat2, done2, ready2});
      end
      valid  = 1'b0;
      valid2 = 1'b0;
      rst_n  = 1'b1;
      capture(8, -1, -1);
      for (int k = 0; k < 8; k++) begin
         n_vec++;
         if ({clk_tr[k], clk2_tr[k], rdy_tr[k], rdy2_tr[k]} !== 4'b0011) begin
            n_err++;
            $display("FAIL reset_no_accept k=%0d: clk,clk2,rdy,rdy2=%b expected 0011", k,
                     {clk_tr[k], clk2_tr[k], rdy_tr[k], rdy2_tr[k]});
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp_bits;
      int rises, dones;
      exp_bits = 8'b1010_0101;
      accept(8'hA5, 1'b0);
      capture(100, -1, -1);
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if ({clk_tr[3+8*i], clk_tr[4+8*i]} !== 2'b01) begin
            n_err++;
            $display("FAIL basic_rise%0d: clk before/at=%b%b expected 01", i, clk_tr[3+8*i], clk_tr[4+8*i]);
         end
         for (int j = 3; j < 8; j++) begin
            n_vec++;
            if (dat_tr[j+8*i] !== exp_bits[7-i]) begin
               n_err++;
               $display("FAIL basic_dat%0d k=%0d: dat=%b expected %b", i, j+8*i, dat_tr[j+8*i], exp_bits[7-i]);
            end
         end
      end
      rises = 0;
      dones = 0;
      for (int k = 1; k < 100; k++) if (clk_tr[k] && !clk_tr[k-1]) rises++;
      for (int k = 0; k < 100; k++) if (done_tr[k]) dones++;
      n_vec++;
      if (rises !== 8) begin
         n_err++;
         $display("FAIL basic_rise_count: %0d rises expected 8", rises);
      end
      n_vec++;
      if (done_tr[64] !== 1'b1 || dones !== 1) begin
         n_err++;
         $display("FAIL basic_done: done@64=%b count=%0d expected 1 and 1", done_tr[64], dones);
      end
      n_vec++;
      if ({rdy_tr[0], rdy_tr[64], rdy_tr[79], rdy_tr[80]} !== 4'b0001) begin
         n_err++;
         $display("FAIL basic_ready: rdy@0,64,79,80=%b expected 0001",
                  {rdy_tr[0], rdy_tr[64], rdy_tr[79], rdy_tr[80]});
      end
   endtask

   task automatic test_loopback();
      rx_bits  = 0;
      rx_words = 0;
      accept(8'h3C, 1'b0);
      capture(100, -1, -1);
      n_vec++;
      if (rx_words !== 1 || rx_last !== 8'd60) begin
         n_err++;
         $display("FAIL loopback_word: words=%0d last=%0d expected 1 and 60", rx_words, rx_last);
      end
      for (int k = 64; k < 100; k++) begin
         n_vec++;
         if ({clk_tr[k], dat_tr[k]} !== 2'b00) begin
            n_err++;
            $display("FAIL loopback_gap k=%0d: clk,dat=%b expected 00", k, {clk_tr[k], dat_tr[k]});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] first;
      first = 8'h01;
      accept(first, 1'b1);
      word = 8'hFF;
      capture(150, -1, -1);
      valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if ({clk_tr[3+8*i], clk_tr[4+8*i], dat_tr[4+8*i]} !== {2'b01, first[7-i]}) begin
            n_err++;
            $display("FAIL b2b_first%0d: clk,clk,dat=%b expected %b", i,
                     {clk_tr[3+8*i], clk_tr[4+8*i], dat_tr[4+8*i]}, {2'b01, first[7-i]});
         end
         n_vec++;
         if ({clk_tr[84+8*i], clk_tr[85+8*i], dat_tr[85+8*i]} !== 3'b011) begin
            n_err++;
            $display("FAIL b2b_second%0d: clk,clk,dat=%b expected 011", i,
                     {clk_tr[84+8*i], clk_tr[85+8*i], dat_tr[85+8*i]});
         end
      end
      for (int k = 64; k < 80; k++) begin
         n_vec++;
         if (clk_tr[k] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap k=%0d: clk=%b expected 0", k, clk_tr[k]);
         end
      end
      n_vec++;
      if ({rdy_tr[79], rdy_tr[80], rdy_tr[81], done_tr[64], done_tr[145]} !== 5'b01011) begin
         n_err++;
         $display("FAIL b2b_handshake: rdy79,80,81 done64,145=%b expected 01011",
                  {rdy_tr[79], rdy_tr[80], rdy_tr[81], done_tr[64], done_tr[145]});
      end
      capture(40, -1, -1);
      n_vec++;
      if ({rdy_tr[10], rdy_tr[11], rdy_tr[39]} !== 3'b011) begin
         n_err++;
         $display("FAIL b2b_ready_after: rdy@160,161,189=%b expected 011", {rdy_tr[10], rdy_tr[11], rdy_tr[39]});
      end
      for (int k = 0; k < 40; k++) begin
         n_vec++;
         if (clk_tr[k] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_no_third k=%0d: clk=%b expected 0", k + 150, clk_tr[k]);
         end
      end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] w2;
      int dones;
      w2 = 8'h5A;
      accept(8'hC3, 1'b0);
      capture(30, -1, -1);
      n_vec++;
      if (clk_tr[29] !== 1'b1) begin
         n_err++;
         $display("FAIL abort_pre: clk@29=%b expected 1", clk_tr[29]);
      end
      @(posedge sysclk);
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({clk, dat, done} !== 3'b000) begin
         n_err++;
         $display("FAIL abort_immediate: clk,dat,done=%b expected 000", {clk, dat, done});
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge sysclk);
         n_vec++;
         if ({clk, done} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_hold%0d: clk,done=%b expected 00", k, {clk, done});
         end
      end
      rst_n = 1'b1;
      capture(20, -1, -1);
      dones = 0;
      for (int k = 0; k < 20; k++) if (done_tr[k] || clk_tr[k]) dones++;
      n_vec++;
      if (dones !== 0 || rdy_tr[0] !== 1'b1) begin
         n_err++;
         $display("FAIL abort_release: activity=%0d ready=%b expected 0 and 1", dones, rdy_tr[0]);
      end
      accept(w2, 1'b0);
      capture(100, -1, -1);
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if ({clk_tr[3+8*i], clk_tr[4+8*i], dat_tr[4+8*i]} !== {2'b01, w2[7-i]}) begin
            n_err++;
            $display("FAIL abort_fresh%0d: clk,clk,dat=%b expected %b", i,
                     {clk_tr[3+8*i], clk_tr[4+8*i], dat_tr[4+8*i]}, {2'b01, w2[7-i]});
         end
      end
      n_vec++;
      if ({done_tr[63], done_tr[64], done_tr[65], rdy_tr[80]} !== 4'b0101) begin
         n_err++;
         $display("FAIL abort_fresh_done: done63,64,65 rdy80=%b expected 0101",
                  {done_tr[63], done_tr[64], done_tr[65], rdy_tr[80]});
      end
   endtask

   task automatic test_small_config();
      logic [3:0] exp_bits;
      int dones;
      exp_bits = 4'b1001;
      accept2(4'h9);
      capture(24, -1, -1);
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({clk2_tr[1+4*i], clk2_tr[2+4*i], dat2_tr[2+4*i]} !== {2'b01, exp_bits[3-i]}) begin
            n_err++;
            $display("FAIL small_rise%0d: clk,clk,dat=%b expected %b", i,
                     {clk2_tr[1+4*i], clk2_tr[2+4*i], dat2_tr[2+4*i]}, {2'b01, exp_bits[3-i]});
         end
      end
      dones = 0;
      for (int k = 0; k < 24; k++) if (done2_tr[k]) dones++;
      n_vec++;
      if (done2_tr[16] !== 1'b1 || dones !== 1) begin
         n_err++;
         $display("FAIL small_done: done@16=%b count=%0d expected 1 and 1", done2_tr[16], dones);
      end
      n_vec++;
      if ({rdy2_tr[15], rdy2_tr[16], rdy2_tr[17]} !== 3'b001) begin
         n_err++;
         $display("FAIL small_ready: rdy@15,16,17=%b expected 001", {rdy2_tr[15], rdy2_tr[16], rdy2_tr[17]});
      end
   endtask

   task automatic test_valid_ignored();
      logic [7:0] w;
      int dones, rises;
      w = 8'h96;
      accept(w, 1'b0);
      capture(100, 10, 21);
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if ({clk_tr[3+8*i], clk_tr[4+8*i], dat_tr[4+8*i]} !== {2'b01, w[7-i]}) begin
            n_err++;
            $display("FAIL ignore_rise%0d: clk,clk,dat=%b expected %b", i,
                     {clk_tr[3+8*i], clk_tr[4+8*i], dat_tr[4+8*i]}, {2'b01, w[7-i]});
         end
      end
      dones = 0;
      rises = 0;
      for (int k = 0; k < 100; k++) if (done_tr[k]) dones++;
      for (int k = 65; k < 100; k++) if (clk_tr[k]) rises++;
      n_vec++;
      if (done_tr[64] !== 1'b1 || dones !== 1 || rises !== 0) begin
         n_err++;
         $display("FAIL ignore_done: done@64=%b count=%0d late_clk=%0d expected 1,1,0", done_tr[64], dones, rises);
      end
      n_vec++;
      if ({rdy_tr[79], rdy_tr[80]} !== 2'b01) begin
         n_err++;
         $display("FAIL ignore_ready: rdy@79,80=%b expected 01", {rdy_tr[79], rdy_tr[80]});
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_loopback();
      test_back_to_back();
      test_reset_mid_word();
      test_small_config();
      test_valid_ignored();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
